// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 4-bit CPU: steps FETCH->DECODE->EXEC->WB,
// decodes the datapath strobes from the state and latched opcode, and counts retired instructions.
module cpu_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             resume,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             carry,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [3:0]       alu_op,
    output logic             acc_sync,
    output logic             acc_we,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic [3:0] op_q;
    logic       is_acc;
    logic       is_mem;

    // run is a level sampled only at instruction boundaries (IDLE, WB, leaving HALT);
    // resume is a one-cycle pulse that matters only while in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= 4'h0;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= (opcode == OP_HLT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                S_WB: begin
                    if (retired != CNT_MAX) retired <= retired + CNT_ONE;
                    state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
                    if (resume) begin
                        if (retired != CNT_MAX) retired <= retired + CNT_ONE;
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Opcode classes; reserved 4'hE falls into neither and behaves as NOP.
    always_comb begin
        is_acc = 1'b0;
        is_mem = 1'b0;
        case (op_q)
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                is_acc = 1'b1;
                is_mem = 1'b1;
            end
            4'h8, 4'hC, 4'hD: begin
                is_acc = 1'b1;
            end
            default: begin
                is_acc = 1'b0;
                is_mem = 1'b0;
            end
        endcase
    end

    always_comb begin
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        alu_op   = 4'h0;
        acc_sync = 1'b0;
        acc_we   = 1'b0;
        halted   = 1'b0;
        busy     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_ld  = 1'b1;
                mem_rd = 1'b1;
                pc_inc = 1'b1;
                busy   = 1'b1;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXEC: begin
                busy     = 1'b1;
                alu_op   = op_q;
                mem_rd   = is_mem;
                mem_wr   = (op_q == OP_STA);
                acc_sync = is_acc;
                // Branch flags are live inputs here, not latched copies.
                pc_ld    = (op_q == OP_JMP) ||
                           ((op_q == OP_JZ) && zero) ||
                           ((op_q == OP_JC) && carry);
            end
            S_WB: begin
                busy   = 1'b1;
                acc_we = is_acc;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: randomized instruction stream, per-instruction expected traces
// queued by the driver and checked cycle by cycle by an independent monitor.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       resume = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       carry = 1'b0;

    logic       ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, acc_sync, acc_we, halted, busy;
    logic [3:0] alu_op;
    logic [7:0] retired;
    logic [2:0] state_dbg;

    logic       ir_ld2, pc_inc2, pc_ld2, mem_rd2, mem_wr2, acc_sync2, acc_we2, halted2, busy2;
    logic [3:0] alu_op2;
    logic [1:0] retired2;
    logic [2:0] state_dbg2;

    int checks = 0;
    int errors = 0;
    int total  = 0;
    int win    = 0;
    bit mon_en = 1'b0;
    bit in_halt = 1'b0;

    logic [20:0] exp_q[$];
    logic [20:0] act_vec;

    always #5 clk = ~clk;

    cpu_ctrl #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .opcode(opcode),
        .zero(zero), .carry(carry), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op), .acc_sync(acc_sync),
        .acc_we(acc_we), .halted(halted), .busy(busy), .retired(retired),
        .state_dbg(state_dbg)
    );

    cpu_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .resume(resume), .opcode(opcode),
        .zero(zero), .carry(carry), .ir_ld(ir_ld2), .pc_inc(pc_inc2), .pc_ld(pc_ld2),
        .mem_rd(mem_rd2), .mem_wr(mem_wr2), .alu_op(alu_op2), .acc_sync(acc_sync2),
        .acc_we(acc_we2), .halted(halted2), .busy(busy2), .retired(retired2),
        .state_dbg(state_dbg2)
    );

    assign act_vec = {ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, alu_op,
                      acc_sync, acc_we, halted, busy, retired};

    function automatic logic [20:0] mk(input logic il, input logic pi, input logic pl,
                                       input logic mr, input logic mw, input logic [3:0] alu,
                                       input logic as, input logic aw, input logic h,
                                       input logic b, input logic [7:0] r);
        return {il, pi, pl, mr, mw, alu, as, aw, h, b, r};
    endfunction

    function automatic logic [7:0] ret8();
        int v;
        v = (total > 255) ? 255 : total;
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what one instruction looks like over its first four cycles.
    task automatic push_trace(input logic [3:0] op, input logic z, input logic c);
        logic acc, mem, br;
        logic [7:0] r;
        r   = ret8();
        acc = op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hD};
        mem = op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        br  = (op == 4'h9) || (op == 4'hA && z) || (op == 4'hB && c);
        exp_q.push_back(mk(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 1, r));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, r));
        if (op == 4'hF) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, r));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, r));
        end else begin
            exp_q.push_back(mk(0, 0, br, mem, op == 4'h2, op, acc, 0, 0, 1, r));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0, acc, 0, 1, r));
        end
    endtask

    task automatic drive_noise();
        opcode = 4'($urandom_range(0, 15));
        zero   = 1'($urandom_range(0, 1));
        carry  = 1'($urandom_range(0, 1));
        run    = 1'($urandom_range(0, 1));
        resume = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in FETCH; returns with the DUT in FETCH again.
    task automatic do_instr(input logic [3:0] op, input logic cont, input int hold,
                            input logic z, input logic c, input int idle);
        push_trace(op, z, c);
        drive_noise();
        step();
        drive_noise();
        opcode = op;
        step();
        if (op != 4'hF) begin
            drive_noise();
            zero  = z;
            carry = c;
            step();
            drive_noise();
            run = cont;
            step();
        end else begin
            in_halt = 1'b1;
            repeat (hold) begin
                drive_noise();
                resume = 1'b0;
                step();
            end
            drive_noise();
            resume = 1'b1;
            run    = cont;
            step();
            in_halt = 1'b0;
        end
        total++;
        if (!cont) begin
            repeat (idle) begin
                drive_noise();
                run = 1'b0;
                step();
            end
            drive_noise();
            run = 1'b1;
            step();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (win > 0 || ir_ld) begin
                if (exp_q.size() == 0) begin
                    check("trace_queue_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("instr_trace", 32'(act_vec), 32'(exp_q.pop_front()));
                end
                win = (win > 0) ? win - 1 : 3;
            end else begin
                check("between_instr", 32'(act_vec),
                      32'(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, in_halt, 0, ret8())));
            end
            check("retired_cntw2", 32'(retired2), (total > 3) ? 32'd3 : 32'(total));
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'(act_vec), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
        run = 1'b1;
        step();

        repeat (5) do_instr(4'h0, 1, 1, 0, 0, 0);
        do_instr(4'h3, 1, 1, 0, 0, 0);
        do_instr(4'h2, 1, 1, 1, 1, 0);
        do_instr(4'hA, 1, 1, 1, 0, 0);
        do_instr(4'hA, 1, 1, 0, 1, 0);
        do_instr(4'hB, 1, 1, 0, 1, 0);
        do_instr(4'hF, 1, 10, 0, 0, 0);
        do_instr(4'h1, 0, 1, 0, 0, 3);
        do_instr(4'hE, 1, 1, 1, 1, 0);
        do_instr(4'hF, 0, 2, 0, 0, 2);

        for (int i = 0; i < 320; i++) begin
            do_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                     $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        do_instr(4'h9, 0, 1, 0, 0, 0);
        // DUT is now in FETCH of an ADD that gets reset in EXEC.
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("retired_saturated", 32'(retired), 32'hFF);
        drive_noise();
        step();
        opcode = 4'h3;
        step();
        check("exec_before_reset", 32'({alu_op, acc_sync, busy}), 32'({4'h3, 1'b1, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("reset_in_exec", 32'(act_vec), 32'd0);
        check("reset_in_exec_cntw2", 32'({retired2, busy2, acc_sync2}), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
